cmd_sequencer: RTL

Host-side command scheduler that sits in front of `CommMaster` and sequences queued copter commands over the wireless link. It holds a small FIFO of command/data pairs and issues them one at a time through `CommMaster`'s `send_cmd`/`resp_rdy` handshake. For each command it waits for the response with a per-command timeout, checks for positive acknowledge, and retries on failure. Test benches and the host controller use it to run whole flight scripts (calibrate, set thrust, set attitude…) without hand-written fork/timeout blocks.

---
 rtl/cmd_seq_pkg.sv | 25 ++
 rtl/cmd_sequencer_if.sv | 20 ++
 rtl/cmd_fifo.sv | 61 ++++++
 rtl/cmd_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cmd_seq_pkg.sv
// rtl/cmd_seq_pkg.sv - shared states, opcodes and error codes for the command sequencer
package cmd_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_SNT,
        S_WAIT_RESP,
        S_CHECK,
        S_ERR
    } state_e;

    localparam logic [7:0] POS_ACK = 8'hA5;

    localparam logic [7:0] CMD_SET_PTCH  = 8'h02;
    localparam logic [7:0] CMD_SET_ROLL  = 8'h03;
    localparam logic [7:0] CMD_SET_YAW   = 8'h04;
    localparam logic [7:0] CMD_SET_THRST = 8'h05;
    localparam logic [7:0] CMD_CALIBRATE = 8'h06;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_TMO  = 2'b01;
    localparam logic [1:0] ERR_NACK = 2'b10;

endpackage

// File: rtl/cmd_sequencer_if.sv
// rtl/cmd_sequencer_if.sv - command/response handshake between the sequencer and CommMaster
interface cmd_sequencer_if;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        send_cmd;
    logic        frm_snt;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        clr_resp_rdy;

    modport master (
        output cmd, data, send_cmd, clr_resp_rdy,
        input  frm_snt, resp_rdy, resp
    );

    modport slave (
        input  cmd, data, send_cmd, clr_resp_rdy,
        output frm_snt, resp_rdy, resp
    );
endinterface

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous command/data FIFO with flush
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot this cycle, so a push while full still lands.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
            else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/cmd_sequencer.sv
// rtl/cmd_sequencer.sv - queues copter commands and issues them to CommMaster with timeout and retry
module cmd_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int TMO_W     = 26,
    parameter int SHORT_TMO = 150_000,
    parameter int LONG_TMO  = 15_000_000,
    parameter int MAX_RETRY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [7:0]              push_cmd,
    input  logic [15:0]             push_data,
    output logic                    full,
    output logic                    empty,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [1:0]              err_code,
    input  logic                    abort,
    cmd_sequencer_if.master         cm
);
    localparam int RW = $clog2(MAX_RETRY + 1) + 1;

    state_e            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d, resp_q, resp_d;
    logic [15:0]       data_q, data_d;
    logic              send_q, send_d, clr_q, clr_d, done_q, done_d;
    logic              busy_q, busy_d, err_q, err_d;
    logic [1:0]        err_code_q, err_code_d, fail_code;
    logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_limit;
    logic [RW-1:0]     retry_q, retry_d;
    logic              pop, flush, retry_path, tmo_exp;
    logic [23:0]       head;

    cmd_fifo #(.DEPTH(DEPTH), .WIDTH(24)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   ({push_cmd, push_data}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign tmo_limit = (cmd_q == CMD_CALIBRATE) ? TMO_W'(LONG_TMO) : TMO_W'(SHORT_TMO);
    // The SEND cycle is cycle 1 of an attempt, so a retry lands exactly tmo_limit cycles later.
    assign tmo_exp   = (tmo_q == tmo_limit - TMO_W'(1));

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        resp_d     = resp_q;
        send_d     = 1'b0;
        clr_d      = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        err_code_d = err_code_q;
        tmo_d      = tmo_q;
        retry_d    = retry_q;
        pop        = 1'b0;
        flush      = 1'b0;
        retry_path = 1'b0;
        fail_code  = ERR_NONE;
        if (abort) begin
            state_d    = S_IDLE;
            flush      = 1'b1;
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
            retry_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Skip the done cycle so the next launch is two cycles after done.
                    if (!empty && !done_q) begin
                        cmd_d   = head[23:16];
                        data_d  = head[15:0];
                        send_d  = 1'b1;
                        state_d = S_SEND;
                    end
                end
                S_SEND: begin
                    tmo_d   = TMO_W'(1);
                    state_d = S_WAIT_SNT;
                end
                S_WAIT_SNT, S_WAIT_RESP: begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (cm.resp_rdy) begin
                        resp_d  = cm.resp;
                        clr_d   = 1'b1;
                        state_d = S_CHECK;
                    end else if (tmo_exp) begin
                        retry_path = 1'b1;
                        fail_code  = ERR_TMO;
                    end else if (state_q == S_WAIT_SNT && cm.frm_snt) begin
                        state_d = S_WAIT_RESP;
                    end
                end
                S_CHECK: begin
                    if (resp_q == POS_ACK) begin
                        pop     = 1'b1;
                        done_d  = 1'b1;
                        retry_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        retry_path = 1'b1;
                        fail_code  = ERR_NACK;
                    end
                end
                default: state_d = state_q;
            endcase
            if (retry_path) begin
                if (retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + RW'(1);
                    send_d  = 1'b1;
                    state_d = S_SEND;
                end else begin
                    err_d      = 1'b1;
                    err_code_d = fail_code;
                    state_d    = S_ERR;
                end
            end
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            data_q     <= '0;
            resp_q     <= '0;
            send_q     <= 1'b0;
            clr_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            tmo_q      <= '0;
            retry_q    <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            resp_q     <= resp_d;
            send_q     <= send_d;
            clr_q      <= clr_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            tmo_q      <= tmo_d;
            retry_q    <= retry_d;
        end
    end

    assign cm.cmd          = cmd_q;
    assign cm.data         = data_q;
    assign cm.send_cmd     = send_q;
    assign cm.clr_resp_rdy = clr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign err_code        = err_code_q;
endmodule
